ll_window_acc: RTL and testbench

Line-length feature accumulator for the LL computation unit. Consumes the signed sample stream, forms |x[n] − x[n−1]| for each new sample, and keeps an exact running sum of the last `win_len` absolute differences in a sliding window. Sits directly downstream of the sample delay register. Feeds the LL threshold and compare logic with one feature value per accepted sample once the window is full.

---
 rtl/ll_pkg.sv | 19 +
 rtl/ll_ring_buf.sv | 29 ++
 rtl/ll_window_acc.sv | 123 ++++++++++++
 tb/tb_ll_window_acc.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared width helpers and default sizing for the line-length (LL) feature path.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package ll_pkg;

  localparam int LL_INPUT_WIDTH = 32;
  localparam int LL_WIN_LEN     = 256;

  // |a - b| of two W-bit signed samples needs W+1 bits unsigned.
  function automatic int ll_absd_w(input int input_width);
    return input_width + 1;
  endfunction

  // The sum of win_len such values needs log2(win_len) extra bits, so the sum never saturates.
  function automatic int ll_sum_w(input int input_width, input int win_len);
    return input_width + 1 + $clog2(win_len);
  endfunction

endpackage

// File: rtl/ll_ring_buf.sv
// Ring storage for the last win_len absolute differences.
// Latency: 1 cycle, synchronous read; a same-address access returns the value held before the write.
// Backpressure: none; one read and one write every cycle.
// Ports: clk; rd_en/rd_addr -> rd_data (registered); wr_en/wr_addr/wr_data.
module ll_ring_buf #(
  parameter int depth = 256,
  parameter int width = 33
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [width-1:0]         rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [width-1:0]         wr_data
);

  logic [width-1:0] mem [depth];

  // The read and the write happen in the same block at the same edge. As a result rd_data
  // holds the slot's value from before the write, which is the value about to leave the window.
  // There is no reset on purpose. Slots written before a restart are masked by the fill
  // count upstream.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/ll_window_acc.sv
// Sliding-window sum of |x[n]-x[n-1]| over the last win_len differences.
// Latency: a sample accepted in cycle t gives ll_valid during cycle t+2. Throughput: 1 sample per clock.
// Backpressure: none. Every din_valid sample is consumed unless clr or rst drops it.
// Ports: clk, rst (sync, active high), clr (window restart), din/din_valid in;
//        ll_out (window sum), ll_valid (1-cycle strobe), win_full (level) out.
module ll_window_acc
  import ll_pkg::*;
#(
  parameter int input_width = LL_INPUT_WIDTH,
  parameter int win_len     = LL_WIN_LEN
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clr,
  input  logic signed [input_width-1:0]             din,
  input  logic                                      din_valid,
  output logic [ll_sum_w(input_width, win_len)-1:0] ll_out,
  output logic                                      ll_valid,
  output logic                                      win_full
);

  localparam int AW = ll_absd_w(input_width);
  localparam int SW = ll_sum_w(input_width, win_len);
  localparam int PW = $clog2(win_len);
  localparam int FW = PW + 1;

  // ---------------- stage 0: acceptance, diff/abs, ring addressing ----------------
  logic signed [input_width-1:0] prev;
  logic                          has_prev;
  logic [FW-1:0]                 fill;
  logic [PW-1:0]                 wr_ptr;

  logic signed [AW-1:0] diff;
  logic [AW-1:0]        absd;
  logic                 do_upd;

  // Sign-extend both operands by one bit. The difference of two W-bit values then always fits.
  assign diff   = {din[input_width-1], din} - {prev[input_width-1], prev};
  assign absd   = diff[AW-1] ? AW'(-diff) : AW'(diff);
  assign do_upd = din_valid & has_prev & ~clr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev     <= '0;
      has_prev <= 1'b0;
      fill     <= '0;
      wr_ptr   <= '0;
    end else if (din_valid) begin
      prev     <= din;
      has_prev <= 1'b1;
      if (has_prev) begin
        wr_ptr <= wr_ptr + 1'b1;  // win_len is a power of two, so this wraps with no bubble
        if (fill != FW'(win_len)) fill <= fill + 1'b1;
      end
    end
  end

  logic [AW-1:0] rd_data;

  ll_ring_buf #(
    .depth (win_len),
    .width (AW)
  ) u_ring (
    .clk     (clk),
    .rd_en   (do_upd),
    .rd_addr (wr_ptr),
    .rd_data (rd_data),
    .wr_en   (do_upd),
    .wr_addr (wr_ptr),
    .wr_data (absd)
  );

  // ---------------- stage 1: absd, old-slot flags ----------------
  logic          s1_vld;
  logic          s1_mask;  // the window was already full, so the slot read holds a live value
  logic          s1_full;  // the window is full after this update
  logic [AW-1:0] s1_absd;
  logic [AW-1:0] old;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_vld  <= 1'b0;
      s1_mask <= 1'b0;
      s1_full <= 1'b0;
      s1_absd <= '0;
    end else begin
      s1_vld <= do_upd;
      if (do_upd) begin
        s1_absd <= absd;
        s1_mask <= (fill == FW'(win_len));
        s1_full <= (fill >= FW'(win_len - 1));
      end
    end
  end

  assign old = s1_mask ? rd_data : '0;

  // ---------------- stage 2: running sum and outputs ----------------
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_nxt;

  // old is always one of the terms already in sum, so the subtraction cannot underflow.
  assign sum_nxt = sum + SW'(s1_absd) - SW'(old);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum      <= '0;
      ll_out   <= '0;
      ll_valid <= 1'b0;
      win_full <= 1'b0;
    end else begin
      ll_valid <= s1_vld & s1_full;
      if (s1_vld) begin
        sum <= sum_nxt;
        if (s1_full) begin
          ll_out   <= sum_nxt;
          win_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ll_window_acc.sv
// Directed bench for ll_window_acc with input_width=8 and win_len=4 (ll_out is 11 bits).
// A negedge collector records every ll_out qualified by ll_valid. The directed cases then compare those values,
// and the outputs at fixed cycle offsets, against hand-computed values.
module tb_ll_window_acc;

  localparam int IW = 8;
  localparam int WL = 4;
  localparam int OW = IW + 1 + $clog2(WL);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 clr = 1'b0;
  logic signed [IW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic [OW-1:0]        ll_out;
  logic                 ll_valid;
  logic                 win_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] got_q [$];

  ll_window_acc #(.input_width(IW), .win_len(WL)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .ll_out    (ll_out),
    .ll_valid  (ll_valid),
    .win_full  (win_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ll_valid) got_q.push_back(ll_out);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic signed [IW-1:0] v);
    din       = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic signed [IW-1:0] seq1 [7] = '{8'sd0, 8'sd10, 8'sd4, 8'sd4, -8'sd6, 8'sd4, 8'sd4};

  initial begin
    // ---- reset state ----
    do_reset();
    check("rst_ll_out", 32'(ll_out), 0);
    check("rst_ll_valid", 32'(ll_valid), 0);
    check("rst_win_full", 32'(win_full), 0);

    // ---- basic sum, latency, slide ----
    for (int i = 0; i < 5; i++) push(seq1[i]);
    check("lat_no_valid_t1", 32'(ll_valid), 0);
    check("lat_no_full_t1", 32'(win_full), 0);
    push(seq1[5]);
    check("basic_valid", 32'(ll_valid), 1);
    check("basic_sum", 32'(ll_out), 26);
    check("basic_full", 32'(win_full), 1);
    push(seq1[6]);
    check("slide1_valid", 32'(ll_valid), 1);
    check("slide1_sum", 32'(ll_out), 26);
    idle(1);
    check("slide2_valid", 32'(ll_valid), 1);
    check("slide2_sum", 32'(ll_out), 20);
    idle(1);
    check("strobe_drop", 32'(ll_valid), 0);
    check("idle_hold", 32'(ll_out), 20);
    check("basic_pulses", 32'(got_q.size()), 3);

    // ---- extremes: every absd = 255 ----
    do_reset();
    got_q.delete();
    for (int i = 0; i < 9; i++) push((i % 2 == 0) ? 8'sh80 : 8'sh7f);
    idle(3);
    check("ext_pulses", 32'(got_q.size()), 5);
    foreach (got_q[i]) check($sformatf("ext_sum%0d", i), 32'(got_q[i]), 1020);

    // ---- gaps: same stimulus as the basic case with random idles ----
    do_reset();
    got_q.delete();
    for (int i = 0; i < 7; i++) begin
      push(seq1[i]);
      idle($urandom_range(0, 3));
    end
    idle(3);
    check("gap_pulses", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      check("gap_sum0", 32'(got_q[0]), 26);
      check("gap_sum1", 32'(got_q[1]), 26);
      check("gap_sum2", 32'(got_q[2]), 20);
    end
    idle(4);
    check("gap_hold", 32'(ll_out), 20);
    check("gap_full", 32'(win_full), 1);

    // ---- mid-run reset with the window full ----
    do_reset();
    got_q.delete();
    check("mrst_ll_out", 32'(ll_out), 0);
    check("mrst_ll_valid", 32'(ll_valid), 0);
    check("mrst_win_full", 32'(win_full), 0);
    push(8'sd0); push(8'sd1); push(8'sd1); push(8'sd1); push(8'sd1);
    idle(2);
    check("mrst_pulses", 32'(got_q.size()), 1);
    if (got_q.size() == 1) check("mrst_sum", 32'(got_q[0]), 1);

    // ---- clr coincident with the third sample ----
    do_reset();
    got_q.delete();
    push(8'sd0);
    push(8'sd10);
    clr = 1'b1;
    push(8'sd4);
    clr = 1'b0;
    idle(3);
    check("clr_no_pulse", 32'(got_q.size()), 0);
    check("clr_win_full", 32'(win_full), 0);
    // The first fresh sample only loads prev, so four samples give three diffs and no output yet.
    push(8'sd1); push(8'sd2); push(8'sd3); push(8'sd4);
    idle(3);
    check("refill_early", 32'(got_q.size()), 0);
    push(8'sd5);
    idle(2);
    check("refill_pulses", 32'(got_q.size()), 1);
    if (got_q.size() == 1) check("refill_sum", 32'(got_q[0]), 4);
    check("refill_full", 32'(win_full), 1);

    // ---- clr while a sample is still in the pipeline ----
    push(8'sd9);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle(3);
    check("inflight_pulses", 32'(got_q.size()), 1);
    check("inflight_full", 32'(win_full), 0);
    check("inflight_ll_out", 32'(ll_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
